// File: rtl/gpu_vram_pkg.sv
// rtl/gpu_vram_pkg.sv - shared widths, scheduler states and grant encoding
package gpu_vram_pkg;

  localparam int ADDR_W_DEFAULT  = 18;
  localparam int COLOR_W_DEFAULT = 16;

  typedef enum logic [1:0] {
    ST_ARB,
    ST_CLEAR,
    ST_DRAIN
  } sched_state_e;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_RAS,
    GNT_HOST,
    GNT_CLR
  } gnt_e;

endpackage

// File: rtl/vram_rr_arbiter.sv
// rtl/vram_rr_arbiter.sv - two-way round-robin between rasterizer and host
module vram_rr_arbiter
  import gpu_vram_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic req_ras,
  input  logic req_host,
  output gnt_e gnt
);

  // last_host=1 means the host won most recently, so the rasterizer wins the next tie
  logic last_host;

  always_comb begin
    gnt = GNT_NONE;
    if (en) begin
      if (req_ras && (!req_host || last_host)) begin
        gnt = GNT_RAS;
      end else if (req_host) begin
        gnt = GNT_HOST;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_host <= 1'b1;
    end else if (gnt == GNT_RAS) begin
      last_host <= 1'b0;
    end else if (gnt == GNT_HOST) begin
      last_host <= 1'b1;
    end
  end

endmodule

// File: rtl/vram_port_scheduler.sv
// rtl/vram_port_scheduler.sv - shares the VRAM write port between raster, host, clear engine and buffer swaps
module vram_port_scheduler
  import gpu_vram_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEFAULT,
  parameter int COLOR_W = COLOR_W_DEFAULT
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_ni,
  input  logic               ras_valid_i,
  output logic               ras_ready_o,
  input  logic [ADDR_W-1:0]  ras_addr_i,
  input  logic [COLOR_W-1:0] ras_color_i,
  input  logic               host_valid_i,
  output logic               host_ready_o,
  input  logic [ADDR_W-1:0]  host_addr_i,
  input  logic [COLOR_W-1:0] host_color_i,
  input  logic               clr_start_i,
  input  logic [ADDR_W-1:0]  clr_base_i,
  input  logic [ADDR_W-1:0]  clr_len_i,
  input  logic [COLOR_W-1:0] clr_color_i,
  output logic               clr_busy_o,
  output logic               clr_done_o,
  input  logic               swap_req_i,
  output logic               swap_done_o,
  input  logic               vram_ready_i,
  output logic [ADDR_W-1:0]  vram_raster_address,
  output logic [COLOR_W-1:0] vram_raster_color,
  output logic               vram_write_pixel,
  output logic               vram_offset
);

  sched_state_e       state_q, state_d;
  logic               clr_pend_q, swap_pend_q, zero_done_q;
  logic [ADDR_W-1:0]  clr_addr_q, clr_rem_q;
  logic [COLOR_W-1:0] clr_col_q;

  logic               slot_free, arb_en, clr_accept;
  gnt_e               arb_gnt, sel;
  logic               clr_take, zero_len, clr_step, clr_last, swap_fire;
  logic [ADDR_W-1:0]  issue_addr;
  logic [COLOR_W-1:0] issue_color;

  assign slot_free  = !vram_write_pixel || vram_ready_i;
  // Requesters only see grants while arbitrating with nothing pending; gated by reset so ready drops with it
  assign arb_en     = wb_rst_ni && (state_q == ST_ARB) && !clr_pend_q && !swap_pend_q && slot_free;
  assign clr_accept = clr_start_i && !clr_pend_q && (state_q != ST_CLEAR);

  vram_rr_arbiter u_arb (
    .clk      (wb_clk_i),
    .rst_n    (wb_rst_ni),
    .en       (arb_en),
    .req_ras  (ras_valid_i),
    .req_host (host_valid_i),
    .gnt      (arb_gnt)
  );

  always_comb begin
    state_d   = state_q;
    sel       = GNT_NONE;
    clr_take  = 1'b0;
    zero_len  = 1'b0;
    clr_step  = 1'b0;
    clr_last  = 1'b0;
    swap_fire = 1'b0;
    case (state_q)
      ST_ARB: begin
        if (clr_pend_q) begin
          clr_take = 1'b1;
          if (clr_rem_q == '0) zero_len = 1'b1;
          else                 state_d  = ST_CLEAR;
        end else if (swap_pend_q) begin
          state_d = ST_DRAIN;
        end else begin
          sel = arb_gnt;
        end
      end
      ST_CLEAR: begin
        if (slot_free) begin
          sel      = GNT_CLR;
          clr_step = 1'b1;
          if (clr_rem_q == ADDR_W'(1)) begin
            clr_last = 1'b1;
            state_d  = ST_ARB;
          end
        end
      end
      ST_DRAIN: begin
        if (!vram_write_pixel) begin
          swap_fire = 1'b1;
          state_d   = ST_ARB;
        end
      end
      default: state_d = ST_ARB;
    endcase
  end

  assign ras_ready_o  = (arb_gnt == GNT_RAS);
  assign host_ready_o = (arb_gnt == GNT_HOST);
  assign clr_busy_o   = (state_q == ST_CLEAR);
  assign clr_done_o   = clr_last || zero_done_q;
  assign swap_done_o  = swap_fire;

  always_comb begin
    issue_addr  = clr_addr_q;
    issue_color = clr_col_q;
    case (sel)
      GNT_RAS: begin
        issue_addr  = ras_addr_i;
        issue_color = ras_color_i;
      end
      GNT_HOST: begin
        issue_addr  = host_addr_i;
        issue_color = host_color_i;
      end
      default: ;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q     <= ST_ARB;
      clr_pend_q  <= 1'b0;
      swap_pend_q <= 1'b0;
      zero_done_q <= 1'b0;
      clr_addr_q  <= '0;
      clr_rem_q   <= '0;
      clr_col_q   <= '0;
      vram_offset <= 1'b0;
    end else begin
      state_q     <= state_d;
      zero_done_q <= zero_len;
      if (clr_accept)    clr_pend_q <= 1'b1;
      else if (clr_take) clr_pend_q <= 1'b0;
      // A request landing in the swap cycle merges into the swap being completed
      if (swap_fire)       swap_pend_q <= 1'b0;
      else if (swap_req_i) swap_pend_q <= 1'b1;
      if (clr_accept) begin
        clr_addr_q <= clr_base_i;
        clr_rem_q  <= clr_len_i;
        clr_col_q  <= clr_color_i;
      end else if (clr_step) begin
        clr_addr_q <= clr_addr_q + ADDR_W'(1);
        clr_rem_q  <= clr_rem_q - ADDR_W'(1);
      end
      if (swap_fire) vram_offset <= !vram_offset;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      vram_write_pixel    <= 1'b0;
      vram_raster_address <= '0;
      vram_raster_color   <= '0;
    end else if (sel != GNT_NONE) begin
      vram_write_pixel    <= 1'b1;
      vram_raster_address <= issue_addr;
      vram_raster_color   <= issue_color;
    end else if (vram_ready_i) begin
      vram_write_pixel    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vram_port_scheduler.sv
// tb/tb_vram_port_scheduler.sv - scoreboard bench with randomized traffic, clears and swaps
module tb_vram_port_scheduler;
  localparam int AW = 18;
  localparam int CW = 16;
  localparam int N_CYC = 3000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ras_valid_i, ras_ready_o, host_valid_i, host_ready_o;
  logic [AW-1:0] ras_addr_i, host_addr_i, clr_base_i, clr_len_i;
  logic [CW-1:0] ras_color_i, host_color_i, clr_color_i;
  logic          clr_start_i, clr_busy_o, clr_done_o, swap_req_i, swap_done_o;
  logic          vram_ready_i, vram_write_pixel, vram_offset;
  logic [AW-1:0] vram_raster_address;
  logic [CW-1:0] vram_raster_color;

  always #5 clk = ~clk;

  vram_port_scheduler #(.ADDR_W(AW), .COLOR_W(CW)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .ras_valid_i(ras_valid_i), .ras_ready_o(ras_ready_o), .ras_addr_i(ras_addr_i), .ras_color_i(ras_color_i),
    .host_valid_i(host_valid_i), .host_ready_o(host_ready_o), .host_addr_i(host_addr_i), .host_color_i(host_color_i),
    .clr_start_i(clr_start_i), .clr_base_i(clr_base_i), .clr_len_i(clr_len_i), .clr_color_i(clr_color_i),
    .clr_busy_o(clr_busy_o), .clr_done_o(clr_done_o), .swap_req_i(swap_req_i), .swap_done_o(swap_done_o),
    .vram_ready_i(vram_ready_i), .vram_raster_address(vram_raster_address), .vram_raster_color(vram_raster_color),
    .vram_write_pixel(vram_write_pixel), .vram_offset(vram_offset)
  );

  typedef struct packed {
    logic          is_swap;
    logic [AW-1:0] addr;
    logic [CW-1:0] color;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passed = 0;
  int   clr_out = 0;
  bit   swap_out = 1'b0;
  bit   mon_en = 1'b0;
  logic exp_off = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  // Monitor: every completed VRAM write or buffer swap pops the next expected event
  logic          prev_hold = 1'b0;
  logic [AW-1:0] prev_addr;
  logic [CW-1:0] prev_col;
  always @(negedge clk) begin
    if (mon_en) begin
      if (prev_hold) begin
        check("hold_strobe", vram_write_pixel, 1);
        check("hold_addr", vram_raster_address, prev_addr);
        check("hold_color", vram_raster_color, prev_col);
      end
      check("offset", vram_offset, exp_off);
      if (vram_write_pixel && vram_ready_i) begin
        check("write_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          exp_t e;
          e = exp_q.pop_front();
          check("write_not_swap", e.is_swap, 0);
          check("write_addr", vram_raster_address, e.addr);
          check("write_color", vram_raster_color, e.color);
        end
      end
      if (swap_done_o) begin
        check("swap_expected", (exp_q.size() > 0) && exp_q[0].is_swap, 1);
        check("swap_strobe_low", vram_write_pixel, 0);
        if ((exp_q.size() > 0) && exp_q[0].is_swap) begin
          void'(exp_q.pop_front());
          swap_out = 1'b0;
        end
        exp_off = ~exp_off;
      end
      if (clr_done_o) begin
        check("clr_done_expected", clr_out > 0, 1);
        if (clr_out > 0) clr_out--;
      end
      prev_hold = vram_write_pixel && !vram_ready_i;
      prev_addr = vram_raster_address;
      prev_col  = vram_raster_color;
    end else begin
      prev_hold = 1'b0;
    end
  end

  bit            ras_hs, host_hs, last_host, push_clr, push_swap;
  int            low_run, cur_len, dir_step;
  logic [AW-1:0] p_base, p_len;
  logic [CW-1:0] p_col;

  initial begin
    rst_n = 1'b0;
    {ras_valid_i, host_valid_i, clr_start_i, swap_req_i, vram_ready_i} = '0;
    {ras_addr_i, host_addr_i, clr_base_i, clr_len_i} = '0;
    {ras_color_i, host_color_i, clr_color_i} = '0;
    ras_hs = 0; host_hs = 0; last_host = 1; low_run = 0; cur_len = 0; dir_step = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_strobe", vram_write_pixel, 0);
    check("rst_offset", vram_offset, 0);
    check("rst_busy", clr_busy_o, 0);
    rst_n = 1'b1;
    mon_en = 1'b1;

    for (int cyc = 0; cyc < N_CYC; cyc++) begin
      @(posedge clk);
      #1;
      if (ras_hs) ras_valid_i = 1'b0;
      if (host_hs) host_valid_i = 1'b0;
      if (!ras_valid_i && (cyc < 20 || $urandom_range(0, 9) < 6)) begin
        ras_valid_i = 1'b1;
        ras_addr_i  = (cyc == 0) ? AW'('h00010) : AW'($urandom);
        ras_color_i = (cyc == 0) ? CW'('h1234) : CW'($urandom);
      end
      if (!host_valid_i && (cyc < 20 || $urandom_range(0, 9) < 5)) begin
        host_valid_i = 1'b1;
        host_addr_i  = AW'($urandom);
        host_color_i = CW'($urandom);
      end
      if (cyc < 20) vram_ready_i = 1'b1;
      else if (low_run > 0) begin vram_ready_i = 1'b0; low_run--; end
      else if ($urandom_range(0, 19) == 0) begin vram_ready_i = 1'b0; low_run = 2; end
      else vram_ready_i = ($urandom_range(0, 3) != 0);

      clr_start_i = 1'b0; swap_req_i = 1'b0; push_clr = 0; push_swap = 0;
      if (cyc >= 30 && clr_out == 0 && !swap_out &&
          ((cyc >= 30 && dir_step == 0) || (cyc >= 80 && dir_step == 1) || $urandom_range(0, 39) == 0)) begin
        if (dir_step == 0) begin
          p_base = AW'('h3FFFE); p_len = AW'(4); p_col = CW'('hF800);
        end else if (dir_step == 1) begin
          p_base = AW'($urandom); p_len = '0; p_col = CW'($urandom);
        end else begin
          p_base = ($urandom_range(0, 2) == 0) ? AW'('h3FFFC + $urandom_range(0, 3)) : AW'($urandom);
          p_len  = ($urandom_range(0, 4) == 0) ? '0 : AW'($urandom_range(1, 6));
          p_col  = CW'($urandom);
        end
        dir_step++;
        clr_start_i = 1'b1; clr_base_i = p_base; clr_len_i = p_len; clr_color_i = p_col;
        push_clr = 1; clr_out++; cur_len = int'(p_len);
      end else if (clr_out > 0 && cur_len != 0 && $urandom_range(0, 4) == 0) begin
        clr_start_i = 1'b1;
        clr_base_i = AW'($urandom); clr_len_i = AW'($urandom_range(1, 6)); clr_color_i = CW'($urandom);
      end
      if (cyc >= 25 && ($urandom_range(0, 29) == 0 || (push_clr && $urandom_range(0, 2) == 0))) begin
        swap_req_i = 1'b1;
        if (!swap_out) begin push_swap = 1; swap_out = 1'b1; end
      end

      @(negedge clk);
      check("one_ready", ras_ready_o && host_ready_o, 0);
      if (ras_ready_o) check("ras_ready_needs_valid", ras_valid_i, 1);
      if (host_ready_o) check("host_ready_needs_valid", host_valid_i, 1);
      if (vram_write_pixel && !vram_ready_i) check("stall_no_grant", ras_ready_o || host_ready_o, 0);
      if (ras_valid_i && host_valid_i && (ras_ready_o || host_ready_o))
        check("rr_winner_ras", ras_ready_o, last_host);
      ras_hs  = ras_valid_i && ras_ready_o;
      host_hs = host_valid_i && host_ready_o;
      if (ras_hs) begin exp_q.push_back('{1'b0, ras_addr_i, ras_color_i}); last_host = 0; end
      if (host_hs) begin exp_q.push_back('{1'b0, host_addr_i, host_color_i}); last_host = 1; end
      if (push_clr)
        for (int i = 0; i < int'(p_len); i++) exp_q.push_back('{1'b0, p_base + AW'(i), p_col});
      if (push_swap) exp_q.push_back('{1'b1, AW'(0), CW'(0)});
    end

    @(posedge clk);
    #1;
    ras_valid_i = 1'b0; host_valid_i = 1'b0; clr_start_i = 1'b0; swap_req_i = 1'b0; vram_ready_i = 1'b1;
    begin
      int waited = 0;
      while ((exp_q.size() > 0 || clr_out > 0) && waited < 500) begin
        @(negedge clk);
        waited++;
      end
      @(negedge clk);
      check("drain_complete", (exp_q.size() == 0) && (clr_out == 0), 1);
    end

    // Abort a running clear with the strobe held up, then reset asynchronously
    mon_en = 1'b0;
    @(posedge clk);
    #1;
    clr_start_i = 1'b1; clr_base_i = AW'('h100); clr_len_i = AW'(40); clr_color_i = CW'('h07E0);
    ras_valid_i = 1'b1; host_valid_i = 1'b1;
    @(posedge clk);
    #1;
    clr_start_i = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    vram_ready_i = 1'b0;
    @(negedge clk);
    check("pre_reset_busy", clr_busy_o, 1);
    check("pre_reset_strobe", vram_write_pixel, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_strobe", vram_write_pixel, 0);
    check("arst_addr", vram_raster_address, 0);
    check("arst_color", vram_raster_color, 0);
    check("arst_offset", vram_offset, 0);
    check("arst_busy", clr_busy_o, 0);
    check("arst_done", clr_done_o, 0);
    check("arst_swap_done", swap_done_o, 0);
    check("arst_ras_ready", ras_ready_o, 0);
    check("arst_host_ready", host_ready_o, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    vram_ready_i = 1'b1;
    @(negedge clk);
    check("post_rst_first_ras", ras_ready_o, 1);
    check("post_rst_first_host", host_ready_o, 0);
    @(negedge clk);
    check("post_rst_second_host", host_ready_o, 1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
